// File: rtl/gb_dma_pkg.sv
// Shared definitions for the OAM DMA bus master.
//   OAM_BASE   : first OAM address written by a transfer
//   OAM_LEN    : bytes copied per transfer
//   DMA_REG    : CPU-visible DMA source/start register
//   HRAM_START : first HRAM address (CPU-reachable during a transfer when blocking is enabled)
package gb_dma_pkg;

  localparam logic [15:0] OAM_BASE   = 16'hFE00;
  localparam int unsigned OAM_LEN    = 160;
  localparam logic [15:0] DMA_REG    = 16'hFF46;
  localparam logic [15:0] HRAM_START = 16'hFF80;

  typedef enum logic [1:0] {StIdle, StRead, StWait, StWrite} dma_state_e;

  // Origin of the data a CPU load will see on c_outdata.
  typedef enum logic [1:0] {TagNone, TagBus, TagReg, TagBlocked} ret_tag_e;

  // HRAM FF80..FFFE; FFFF (IE) is not HRAM.
  function automatic logic is_hram(input logic [15:0] addr);
    return (addr >= HRAM_START) && (addr != 16'hFFFF);
  endfunction

endpackage

// File: rtl/dma_ret_pipe.sv
// Return-tag delay line: tags each CPU load so the read data returned Depth cycles later
// can be routed from the bus, the DMA register, or replaced by 0xFF.
//   clock, resetn : clock, asynchronous active-low reset (all stages clear to TagNone)
//   tag_i         : tag of the load issued this cycle
//   tag_o         : tag of the load issued Depth cycles ago
module dma_ret_pipe
  import gb_dma_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clock,
  input  logic     resetn,
  input  ret_tag_e tag_i,
  output ret_tag_e tag_o
);

  ret_tag_e pipe_q [Depth];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < Depth; i++) pipe_q[i] <= TagNone;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < Depth; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[Depth-1];

endmodule

// File: rtl/oam_dma.sv
// OAM DMA bus master. The CPU bus passes through to the decoder bus (m_*); a CPU store to
// 0xFF46 copies 160 bytes from {src,8'h00} to OAM at 0xFE00, one byte per READ_LATENCY+1
// cycles (READ, READ_LATENCY-1 WAIT cycles, WRITE).
// Optional macro: DMA_CPU_BLOCK_EN -- while active, CPU accesses below HRAM are dropped in
// every state; HRAM and 0xFF46 stay reachable in WAIT cycles.
//   clock, resetn   : clock, asynchronous active-low reset
//   c_address/c_indata/c_load/c_store : CPU bus request
//   c_outdata       : CPU read data, READ_LATENCY cycles after c_load
//   m_address/m_indata/m_load/m_store : bus to the memory-map decoders
//   m_outdata       : OR-combined decoder read data, READ_LATENCY cycles after m_load
//   active          : transfer in progress
module oam_dma
  import gb_dma_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] c_address,
  input  logic [7:0]  c_indata,
  output logic [7:0]  c_outdata,
  input  logic        c_load,
  input  logic        c_store,
  output logic [15:0] m_address,
  output logic [7:0]  m_indata,
  input  logic [7:0]  m_outdata,
  output logic        m_load,
  output logic        m_store,
  output logic        active
);

  localparam logic [7:0] LastIdx  = 8'(OAM_LEN - 1);
  localparam logic [1:0] WaitLast = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

  dma_state_e state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] idx_q, idx_d;
  logic [1:0] wait_q, wait_d;

  logic     reg_hit, reg_store, dma_owned, cpu_ok;
  ret_tag_e tag_in, tag_out;

  assign reg_hit   = (c_address == DMA_REG);
  assign reg_store = c_store & reg_hit;
  assign dma_owned = (state_q == StRead) || (state_q == StWrite);
  assign active    = (state_q != StIdle);

  // cpu_ok: a non-register CPU access may reach the decoder bus this cycle.
`ifdef DMA_CPU_BLOCK_EN
  assign cpu_ok = !dma_owned && (!active || is_hram(c_address));
`else
  assign cpu_ok = !dma_owned;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    case (state_q)
      StRead: begin
        wait_d  = '0;
        state_d = (READ_LATENCY > 1) ? StWait : StWrite;
      end
      StWait: begin
        if (wait_q == WaitLast) state_d = StWrite;
        else                    wait_d  = wait_q + 2'd1;
      end
      StWrite: begin
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StIdle;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = StRead;
        end
      end
      default: ;
    endcase
    // The register is internal, so a store to it is honoured in every state and restarts
    // the copy; any byte in flight is abandoned before its WRITE.
    if (reg_store) begin
      src_d   = c_indata;
      idx_d   = '0;
      state_d = StRead;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      src_q   <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    m_address = '0;
    m_indata  = '0;
    m_load    = 1'b0;
    m_store   = 1'b0;
    case (state_q)
      StRead: begin
        m_address = {src_q, idx_q};
        m_load    = 1'b1;
      end
      StWrite: begin
        m_address = OAM_BASE + {8'h00, idx_q};
        m_indata  = m_outdata;
        m_store   = 1'b1;
      end
      default: begin
        if ((c_load || c_store) && !reg_hit && cpu_ok) begin
          m_address = c_address;
          m_indata  = c_indata;
          m_load    = c_load;
          m_store   = c_store;
        end
      end
    endcase
  end

  always_comb begin
    tag_in = TagNone;
    if (c_load) begin
      if (reg_hit)     tag_in = TagReg;
      else if (cpu_ok) tag_in = TagBus;
      else             tag_in = TagBlocked;
    end
  end

  dma_ret_pipe #(
    .Depth (READ_LATENCY)
  ) u_ret_pipe (
    .clock  (clock),
    .resetn (resetn),
    .tag_i  (tag_in),
    .tag_o  (tag_out)
  );

  always_comb begin
    case (tag_out)
      TagBus:     c_outdata = m_outdata;
      TagReg:     c_outdata = src_q;
      TagBlocked: c_outdata = 8'hFF;
      default:    c_outdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: directed CPU traffic against a slave that returns the low address
// byte (0x5A at 0xC000), a transfer-schedule model checked every cycle, and literal
// expectations at the interesting cycles.
module tb_oam_dma;

  localparam int RL     = 2;
  localparam int P      = RL + 1;
  localparam int NBYTES = 160;

  logic        clock = 1'b0;
  logic        resetn;
  logic [15:0] c_address;
  logic [7:0]  c_indata;
  logic [7:0]  c_outdata;
  logic        c_load;
  logic        c_store;
  logic [15:0] m_address;
  logic [7:0]  m_indata;
  logic [7:0]  m_outdata;
  logic        m_load;
  logic        m_store;
  logic        active;

  always #5 clock = ~clock;

  oam_dma #(
    .READ_LATENCY (RL)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .c_address (c_address),
    .c_indata  (c_indata),
    .c_outdata (c_outdata),
    .c_load    (c_load),
    .c_store   (c_store),
    .m_address (m_address),
    .m_indata  (m_indata),
    .m_outdata (m_outdata),
    .m_load    (m_load),
    .m_store   (m_store),
    .active    (active)
  );

  function automatic logic [7:0] slave_f(input logic [15:0] a);
    return (a == 16'hC000) ? 8'h5A : a[7:0];
  endfunction

  // Slave: data for a load appears RL cycles later.
  logic [RL-1:0] sv_vld;
  logic [15:0]   sv_addr [RL];
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sv_vld <= '0;
      for (int i = 0; i < RL; i++) sv_addr[i] <= '0;
    end else begin
      sv_vld[0]  <= m_load;
      sv_addr[0] <= m_address;
      for (int i = 1; i < RL; i++) begin
        sv_vld[i]  <= sv_vld[i-1];
        sv_addr[i] <= sv_addr[i-1];
      end
    end
  end
  assign m_outdata = sv_vld[RL-1] ? slave_f(sv_addr[RL-1]) : 8'h00;

  int n_checks = 0;
  int n_errs   = 0;

  int         cyc;
  int         mdl_t;
  bit         mdl_on;
  logic [7:0] mdl_src;
  int         slot_kind [64];  // 0 none, 1 bus, 2 register, 3 blocked
  logic [7:0] slot_val  [64];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_on  = 0;
    mdl_src = 8'h00;
    for (int i = 0; i < 64; i++) begin
      slot_kind[i] = 0;
      slot_val[i]  = 8'h00;
    end
  endtask

  // Expected outputs for this cycle from the transfer schedule, then advance the model.
  task automatic model_step();
    int         k;
    int         s;
    bit         owned;
    bit         ok;
    logic       e_act, e_ld, e_st;
    logic [15:0] e_a;
    logic [7:0]  e_d, e_c;
    e_act = 0; e_ld = 0; e_st = 0; e_a = '0; e_d = '0; owned = 0;
    k = cyc - mdl_t - 1;
    if (mdl_on && k >= 0 && k < NBYTES * P) begin
      e_act = 1;
      if (k % P == 0) begin
        owned = 1; e_ld = 1; e_a = {mdl_src, 8'(k / P)};
      end else if (k % P == RL) begin
        owned = 1; e_st = 1; e_a = 16'hFE00 + 16'(k / P);
        e_d = slave_f({mdl_src, 8'(k / P)});
      end
    end
`ifdef DMA_CPU_BLOCK_EN
    ok = !owned && (!e_act || (c_address >= 16'hFF80 && c_address != 16'hFFFF));
`else
    ok = !owned;
`endif
    if (ok && (c_load || c_store) && c_address != 16'hFF46) begin
      e_a = c_address; e_d = c_indata; e_ld = c_load; e_st = c_store;
    end
    s = cyc % 64;
    case (slot_kind[s])
      1:       e_c = slot_val[s];
      2:       e_c = mdl_src;
      3:       e_c = 8'hFF;
      default: e_c = 8'h00;
    endcase
    slot_kind[s] = 0;
    chk("mdl_active", 16'(active), 16'(e_act));
    chk("mdl_m_load", 16'(m_load), 16'(e_ld));
    chk("mdl_m_store", 16'(m_store), 16'(e_st));
    chk("mdl_m_address", m_address, e_a);
    chk("mdl_m_indata", 16'(m_indata), 16'(e_d));
    chk("mdl_c_outdata", 16'(c_outdata), 16'(e_c));
    if (c_load) begin
      s = (cyc + RL) % 64;
      if (c_address == 16'hFF46) slot_kind[s] = 2;
      else if (!ok)              slot_kind[s] = 3;
      else begin
        slot_kind[s] = 1;
        slot_val[s]  = slave_f(c_address);
      end
    end
    if (c_store && c_address == 16'hFF46) begin
      mdl_src = c_indata;
      mdl_t   = cyc;
      mdl_on  = 1;
    end
    cyc++;
  endtask

  task automatic tick(input logic ld, input logic st, input logic [15:0] a, input logic [7:0] d);
    @(posedge clock);
    #1;
    c_load = ld; c_store = st; c_address = a; c_indata = d;
    #2;
    model_step();
  endtask

  initial begin
    resetn = 1'b0;
    c_load = 1'b0; c_store = 1'b0; c_address = '0; c_indata = '0;
    cyc = 0; mdl_t = 0;
    model_reset();
    #1;
    chk("rst_active", 16'(active), 16'h0);
    chk("rst_m_load", 16'(m_load), 16'h0);
    chk("rst_m_store", 16'(m_store), 16'h0);
    chk("rst_m_address", m_address, 16'h0);
    chk("rst_c_outdata", 16'(c_outdata), 16'h0);
    @(posedge clock);
    #1 resetn = 1'b1;
    repeat (2) tick(0, 0, 16'h0, 8'h0);

    // Idle pass-through load.
    tick(1, 0, 16'hC000, 8'h0);
    chk("idle_fwd_load", 16'(m_load), 16'h1);
    chk("idle_fwd_addr", m_address, 16'hC000);
    tick(0, 0, 16'h0, 8'h0);
    tick(0, 0, 16'h0, 8'h0);
    chk("idle_ret_data", 16'(c_outdata), 16'h5A);
    chk("idle_active", 16'(active), 16'h0);

    // Transfer from 0xC100.
    tick(0, 1, 16'hFF46, 8'hC1);
    chk("start_not_fwd", 16'(m_store), 16'h0);
    chk("start_active_T", 16'(active), 16'h0);
    tick(0, 0, 16'h0, 8'h0);
    chk("first_read_active", 16'(active), 16'h1);
    chk("first_read_load", 16'(m_load), 16'h1);
    chk("first_read_addr", m_address, 16'hC100);
    tick(0, 0, 16'h0, 8'h0);
    tick(0, 0, 16'h0, 8'h0);
    chk("first_write_store", 16'(m_store), 16'h1);
    chk("first_write_addr", m_address, 16'hFE00);
    chk("first_write_data", 16'(m_indata), 16'h00);
    repeat (12) tick(0, 0, 16'h0, 8'h0);
    tick(1, 0, 16'hC000, 8'h0);
    chk("read_cycle_owned", m_address, 16'hC105);
    tick(1, 0, 16'hFF46, 8'h0);
    chk("reg_load_not_fwd", 16'(m_load), 16'h0);
    tick(0, 0, 16'h0, 8'h0);
    chk("blocked_ret_ff", 16'(c_outdata), 16'hFF);
    tick(0, 0, 16'h0, 8'h0);
    chk("reg_ret_src", 16'(c_outdata), 16'hC1);
    tick(0, 1, 16'hC000, 8'hAB);
`ifdef DMA_CPU_BLOCK_EN
    chk("wait_store_dropped", 16'(m_store), 16'h0);
`else
    chk("wait_store_fwd", 16'(m_store), 16'h1);
`endif
    tick(0, 0, 16'h0, 8'h0);
    tick(0, 0, 16'h0, 8'h0);
    tick(1, 0, 16'hFF80, 8'h0);
    chk("wait_hram_load", 16'(m_load), 16'h1);
    chk("wait_hram_addr", m_address, 16'hFF80);
    repeat (456) tick(0, 0, 16'h0, 8'h0);
    tick(0, 0, 16'h0, 8'h0);
    chk("last_write_store", 16'(m_store), 16'h1);
    chk("last_write_addr", m_address, 16'hFE9F);
    chk("last_write_data", 16'(m_indata), 16'h9F);
    tick(0, 0, 16'h0, 8'h0);
    chk("end_active", 16'(active), 16'h0);

    // Restart mid-transfer.
    repeat (4) tick(0, 0, 16'h0, 8'h0);
    tick(0, 1, 16'hFF46, 8'hC2);
    repeat (99) tick(0, 0, 16'h0, 8'h0);
    tick(0, 1, 16'hFF46, 8'hD0);
    chk("restart_in_read", m_address, 16'hC221);
    tick(0, 0, 16'h0, 8'h0);
    chk("restart_read_addr", m_address, 16'hD000);
    chk("restart_read_load", 16'(m_load), 16'h1);
    chk("restart_no_store0", 16'(m_store), 16'h0);
    tick(0, 0, 16'h0, 8'h0);
    chk("restart_no_store1", 16'(m_store), 16'h0);
    repeat (47) tick(0, 0, 16'h0, 8'h0);

    // Asynchronous reset mid-transfer.
    @(posedge clock);
    #3 resetn = 1'b0;
    #1;
    chk("midrst_active", 16'(active), 16'h0);
    chk("midrst_m_load", 16'(m_load), 16'h0);
    chk("midrst_m_store", 16'(m_store), 16'h0);
    chk("midrst_m_address", m_address, 16'h0);
    chk("midrst_m_indata", 16'(m_indata), 16'h0);
    model_reset();
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    repeat (20) tick(0, 0, 16'h0, 8'h0);
    chk("post_rst_idle", 16'(active), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
